ef_smsdac_rng_sched: RTL and testbench
======================================

Name: ef_smsdac_rng_sched

Overview:
- Scheduler that shares one 10-b, 7-output LFSR random source among NREQ mismatch-shaping consumers in the SMS DAC.
- Owns the LFSR step enable.
- Runs a post-reset warm-up so that consumers never see the sparse initial LFSR states.
- Round-robin arbitrates word requests; each grant delivers a fresh 7-b random word and steps the LFSR, so no word is handed out twice.

Parameters:
- NREQ, 4, number of requesting consumers (2..8).
- RW, 7, random word width; must equal the LFSR tap output width.
- WARMUP, 2, LFSR steps issued after reset before the first grant (1..15).

Ports:
- clk  in  1  clock.
- rst_b  in  1  reset, asynchronous, active-low.
- en  in  1  global enable; low freezes all state, grants and LFSR stepping.
- req  in  NREQ  level request per consumer; each grant consumes one word.
- gnt  out  NREQ  registered one-hot grant pulse, 1 cycle.
- rnd  out  RW  registered random word; valid while gnt is nonzero.
- ready  out  1  registered; high once warm-up is complete.
- lfsr_en  out  1  combinational step enable to the LFSR.
- lfsr_r  in  RW  LFSR tapped output for the current LFSR state.

Behaviour:
- Reset values (async): gnt=0, rnd=0, ready=0, state=WARM, warm counter=0, rr pointer=0.
- FSM, two states:
  - WARM: lfsr_en=en. Counter increments on each en cycle. When the counter reaches WARMUP-1 with en=1, go to RUN and set ready=1 at the same edge. No grants are issued in WARM.
  - RUN: stays in RUN until reset.
- Arbitration (RUN, en=1):
  - eligible = req & ~gnt. The last cycle's grantee is masked for one cycle, so a consumer may drop req in the cycle it sees gnt.
  - Winner = first eligible bit searching upward from ptr, wrapping at NREQ.
  - If eligible != 0, at the clock edge:
    - gnt <= onehot(winner);
    - rnd <= lfsr_r;
    - ptr <= (winner+1) mod NREQ.
  - lfsr_en = 1 in that same cycle, so the LFSR advances at the same edge rnd captures the old word. The next grant therefore always sees a new word.
  - If eligible == 0: gnt <= 0; rnd holds its value; lfsr_en=0 (see optional feature).
- Latency:
  - req to gnt is one clock.
  - Sustained throughput: 1 word/cycle with at least 2 active requesters; 1 word per 2 cycles for a single requester.
- en=0: lfsr_en=0; gnt <= 0; counter, ptr and state hold. rnd holds its value.
- req nonzero during WARM: ignored. The first grant is issued in the first RUN cycle with eligible != 0.
- All requesters active: strict rotation 0,1,..,NREQ-1,0. No requester waits more than NREQ cycles.
- rst_b asserted mid-operation: all outputs return to reset values immediately. The LFSR is on the same rst_b, so warm-up is repeated.

Optional Feature:
- Macro: SMSDAC_RNG_FREERUN_EN.
- Defined: in RUN with en=1, lfsr_en=1 every cycle whether or not a grant is issued. The LFSR free-runs, which decorrelates a word's value from request timing.
- Undefined: in RUN, lfsr_en=1 only in cycles that issue a grant, so the word sequence is deterministic in grant order.
- WARM behaviour is identical in both builds.

Decomposition:
- Shared package ef_smsdac_pkg holds:
  - FSM state enum {WARM, RUN};
  - localparams SMSDAC_RW=7 and SMSDAC_LFSR_N=10.
- One natural sub-module: ef_smsdac_rr_arb, a combinational round-robin picker (eligible, ptr -> winner one-hot, winner index).
- The scheduler instantiates the picker; the LFSR is instantiated at the top level, alongside the scheduler.

Test Plan:
All scenarios use a bench LFSR with reset state 0x001 and default parameters.
- Warm-up: release reset, en=1, req=0 -> lfsr_en high for 2 cycles, ready rises at the 2nd edge, gnt stays 0; LFSR state reaches 0x081.
- First grants: after warm-up, req=4'b0011 held -> gnt=0001 with rnd=0x10, then gnt=0010 with rnd=0x44, then 0001 again; no two rnd values repeat in the first 8 grants.
- Rotation/fairness: req=4'b1111 for 12 cycles -> gnt sequence 0001,0010,0100,1000 repeated 3 times; lfsr_en high all 12 cycles.
- Single requester: req=4'b0100 held -> gnt=0100 every other cycle; lfsr_en toggles 1,0 (undefined macro) or stays 1 (macro defined).
- en gating: drop en for 5 cycles mid-stream with req=4'b1111 -> gnt=0 and lfsr_en=0 throughout; rotation resumes at the next ptr value with the unchanged LFSR word.
- Reset mid-grant: assert rst_b low while gnt=1000 -> gnt=0, rnd=0, ready=0 asynchronously; after release, warm-up repeats and the first rnd is 0x10 again.

Source files
------------

// File: rtl/ef_smsdac_pkg.sv
// Shared types and constants for the SMS DAC random-word scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ef_smsdac_pkg;

    localparam int SMSDAC_RW     = 7;
    localparam int SMSDAC_LFSR_N = 10;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

endpackage

// File: rtl/ef_smsdac_rr_arb.sv
// Round-robin picker: first eligible requester at or above ptr, wrapping at NREQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is consumed.
module ef_smsdac_rr_arb
    import ef_smsdac_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [PW-1:0]   win_idx,
    output logic            win_vld
);

    // Walk NREQ positions starting at ptr; the first eligible one wins.
    always_comb begin
        logic [PW:0] idx;
        idx     = '0;
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(NREQ)) begin
                idx = idx - (PW+1)'(NREQ);
            end
            if (!win_vld && eligible[idx[PW-1:0]]) begin
                win_vld             = 1'b1;
                win_idx             = idx[PW-1:0];
                win_oh[idx[PW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ef_smsdac_rng_sched.sv
// Shares one LFSR word source among NREQ consumers: warm-up, then round-robin grants, one fresh word per grant.
// Latency: req to gnt/rnd one clock; back-to-back grants need two requesters (last grantee masked one cycle).
// Backpressure: en=0 freezes everything; build option SMSDAC_RNG_FREERUN_EN lets the LFSR step every RUN cycle.
module ef_smsdac_rng_sched
    import ef_smsdac_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int RW     = SMSDAC_RW,
    parameter int WARMUP = 2
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [RW-1:0]   rnd,
    output logic            ready,
    output logic            lfsr_en,
    input  logic [RW-1:0]   lfsr_r
);

    localparam int         PW        = $clog2(NREQ);
    localparam logic [3:0] WARM_LAST = 4'(WARMUP - 1);

    sched_state_t    state_q, state_d;
    logic [3:0]      warm_cnt_q, warm_cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            ready_d;
    logic            fire;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] win_oh;
    logic [PW-1:0]   win_idx;
    logic            win_vld;

    // Last cycle's grantee sits out one cycle so it can drop req after seeing gnt.
    assign eligible = req & ~gnt;

    ef_smsdac_rr_arb #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .eligible (eligible),
        .ptr      (ptr_q),
        .win_oh   (win_oh),
        .win_idx  (win_idx),
        .win_vld  (win_vld)
    );

    // Next-state, warm-up count, grant decision and LFSR step enable.
    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        ptr_d      = ptr_q;
        ready_d    = ready;
        fire       = 1'b0;
        lfsr_en    = 1'b0;
        case (state_q)
            WARM: begin
                lfsr_en = en;
                if (en) begin
                    warm_cnt_d = warm_cnt_q + 4'd1;
                    if (warm_cnt_q == WARM_LAST) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end
                end
            end
            RUN: begin
                fire = en & win_vld;
`ifdef SMSDAC_RNG_FREERUN_EN
                lfsr_en = en;
`else
                lfsr_en = fire;
`endif
                if (fire) begin
                    ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
                end
            end
            default: begin
                state_d = WARM;
            end
        endcase
    end

    // FSM state and warm-up counter.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= WARM;
            warm_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
        end
    end

    // Grant pulse, captured word (taken as the LFSR steps past it), rotation pointer and ready flag.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            gnt   <= '0;
            rnd   <= '0;
            ptr_q <= '0;
            ready <= 1'b0;
        end else begin
            gnt   <= fire ? win_oh : '0;
            ptr_q <= ptr_d;
            ready <= ready_d;
            if (fire) begin
                rnd <= lfsr_r;
            end
        end
    end

endmodule

// File: tb/tb_ef_smsdac_rng_sched.sv
// Directed bench for ef_smsdac_rng_sched with a bench-side LFSR source.
// Inputs change at the falling edge; outputs are sampled 1 time unit later.
// Covers warm-up, first grants, rotation, single requester, en gating and mid-grant reset.
module tb_ef_smsdac_rng_sched;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [6:0] rnd;
    logic       ready;
    logic       lfsr_en;
    logic [6:0] lfsr_r;

    logic [9:0] lfsr_q;
    int         n_pass = 0;
    int         n_chk  = 0;

`ifdef SMSDAC_RNG_FREERUN_EN
    localparam logic FREERUN = 1'b1;
`else
    localparam logic FREERUN = 1'b0;
`endif

    // Words expected from the first eight grants, worked out by hand from the bench LFSR.
    logic [6:0] first8 [8] = '{7'h10, 7'h44, 7'h30, 7'h46, 7'h38, 7'h47, 7'h3C, 7'h57};
    logic [6:0] seen   [8];
    logic [6:0] exp_rnd;
    logic [9:0] frozen;
    int         ndist;

    ef_smsdac_rng_sched dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .rnd     (rnd),
        .ready   (ready),
        .lfsr_en (lfsr_en),
        .lfsr_r  (lfsr_r)
    );

    always #5 clk = ~clk;

    // Bench LFSR: Galois right shift, feedback mask 0x102, reset state 0x001, stepped by lfsr_en.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            lfsr_q <= 10'h001;
        end else if (lfsr_en) begin
            lfsr_q <= {1'b0, lfsr_q[9:1]} ^ (lfsr_q[0] ? 10'h102 : 10'h000);
        end
    end

    function automatic logic [6:0] tap(input logic [9:0] s);
        return {s[8], s[5], s[0], s[3], s[1], s[4], s[2]};
    endfunction

    assign lfsr_r = tap(lfsr_q);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic e, input logic [3:0] r);
        @(negedge clk);
        en  = e;
        req = r;
        #1;
    endtask

    initial begin
        rst_b = 1'b0;
        en    = 1'b0;
        req   = 4'b0000;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt",     32'(gnt),     32'h0);
        chk("rst_rnd",     32'(rnd),     32'h0);
        chk("rst_ready",   32'(ready),   32'h0);
        chk("rst_lfsr_en", 32'(lfsr_en), 32'h0);
        rst_b = 1'b1;

        // Warm-up: two steps, no grants, ready after the second edge.
        cyc(1'b1, 4'b0000);
        chk("warm0_lfsr_en", 32'(lfsr_en), 32'h1);
        chk("warm0_ready",   32'(ready),   32'h0);
        cyc(1'b1, 4'b0000);
        chk("warm1_lfsr_en", 32'(lfsr_en), 32'h1);
        chk("warm1_ready",   32'(ready),   32'h0);
        chk("warm1_gnt",     32'(gnt),     32'h0);
        cyc(1'b1, 4'b0011);
        chk("run_ready",      32'(ready),   32'h1);
        chk("run_gnt_idle",   32'(gnt),     32'h0);
        chk("warm_lfsr_state", 32'(lfsr_q), 32'h081);
        chk("first_lfsr_en",  32'(lfsr_en), 32'h1);

        // First eight grants alternate 0 and 1; the last step hands over to requester 3.
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, (k == 7) ? 4'b1000 : 4'b0011);
            chk($sformatf("first_gnt%0d", k), 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
            chk($sformatf("first_rnd%0d", k), 32'(rnd), 32'(first8[k]));
            seen[k] = rnd;
        end
        ndist = 0;
        for (int i = 0; i < 8; i++) begin
            logic dup;
            dup = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (seen[j] == seen[i]) dup = 1'b1;
            end
            if (!dup) ndist++;
        end
        chk("first8_distinct", 32'(ndist), 32'd8);

        // Rotation with all four requesting, starting from pointer 0.
        cyc(1'b1, 4'b1111);
        chk("hand_gnt3",   32'(gnt),     32'h8);
        chk("hand_rnd3",   32'(rnd),     32'h78);
        chk("rot_lfsr_en0", 32'(lfsr_en), 32'h1);
        for (int k = 1; k < 12; k++) begin
            cyc(1'b1, 4'b1111);
            chk($sformatf("rot_gnt%0d", k), 32'(gnt), 32'(1 << ((k - 1) % 4)));
            chk($sformatf("rot_lfsr_en%0d", k), 32'(lfsr_en), 32'h1);
            if (k == 11) exp_rnd = lfsr_r;
        end

        // en low for five cycles: nothing moves.
        frozen = 10'h000;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 4'b1111);
            if (k == 0) frozen = lfsr_q;
            chk($sformatf("gate_gnt%0d", k), 32'(gnt), (k == 0) ? 32'h8 : 32'h0);
            chk($sformatf("gate_lfsr_en%0d", k), 32'(lfsr_en), 32'h0);
            chk($sformatf("gate_rnd%0d", k), 32'(rnd), 32'(exp_rnd));
        end
        cyc(1'b1, 4'b1111);
        chk("gate_resume_gnt0",  32'(gnt),     32'h0);
        chk("gate_resume_en",    32'(lfsr_en), 32'h1);
        chk("gate_lfsr_frozen",  32'(lfsr_q),  32'(frozen));

        // Single requester: grant every other cycle.
        cyc(1'b1, 4'b0100);
        chk("gate_resume_gnt", 32'(gnt), 32'h1);
        chk("gate_resume_rnd", 32'(rnd), 32'(tap(frozen)));
        chk("single_lfsr_en0", 32'(lfsr_en), 32'h1);
        for (int k = 1; k < 6; k++) begin
            cyc(1'b1, 4'b0100);
            chk($sformatf("single_gnt%0d", k), 32'(gnt), (k % 2 == 1) ? 32'h4 : 32'h0);
            chk($sformatf("single_lfsr_en%0d", k), 32'(lfsr_en),
                (k % 2 == 0 || FREERUN) ? 32'h1 : 32'h0);
        end

        // Reset while requester 3 holds the grant.
        cyc(1'b1, 4'b1000);
        chk("pre_rst_gnt0", 32'(gnt), 32'h0);
        cyc(1'b0, 4'b1000);
        chk("pre_rst_gnt3", 32'(gnt), 32'h8);
        rst_b = 1'b0;
        #1;
        chk("async_rst_gnt",     32'(gnt),     32'h0);
        chk("async_rst_rnd",     32'(rnd),     32'h0);
        chk("async_rst_ready",   32'(ready),   32'h0);
        chk("async_rst_lfsr_en", 32'(lfsr_en), 32'h0);
        @(negedge clk);
        #1;
        rst_b = 1'b1;

        // Warm-up repeats; the held request is ignored until RUN.
        cyc(1'b1, 4'b1000);
        chk("rewarm0_lfsr_en", 32'(lfsr_en), 32'h1);
        chk("rewarm0_gnt",     32'(gnt),     32'h0);
        cyc(1'b1, 4'b1000);
        chk("rewarm1_lfsr_en", 32'(lfsr_en), 32'h1);
        chk("rewarm1_ready",   32'(ready),   32'h0);
        chk("rewarm1_gnt",     32'(gnt),     32'h0);
        cyc(1'b1, 4'b1000);
        chk("rerun_ready",   32'(ready),   32'h1);
        chk("rerun_gnt0",    32'(gnt),     32'h0);
        chk("rerun_lfsr_en", 32'(lfsr_en), 32'h1);
        cyc(1'b1, 4'b0000);
        chk("rerun_gnt", 32'(gnt), 32'h8);
        chk("rerun_rnd", 32'(rnd), 32'h10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
